// File: rtl/mem_arbiter.sv
// Round-robin two-requester arbiter and sequencer for the matrix engine scratch memory.
// Drives registered memory pins and returns read data after a fixed three-cycle latency.
module mem_arbiter #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              rw0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              req1_i,
    input  logic              rw1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_en_o,
    output logic              mem_rw_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    logic              last_gnt;
    logic              acc;
    logic              sel;
    logic              sel_rw;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              s1_valid;
    logic              s1_id;
    logic              s2_valid;
    logic              s2_id;

    // On a tie, the requester that was not served last wins.
    assign gnt0_o = req0_i & (~req1_i | last_gnt) & ~rst_i;
    assign gnt1_o = req1_i & (~req0_i | ~last_gnt) & ~rst_i;

    assign acc       = gnt0_o | gnt1_o;
    assign sel       = gnt1_o;
    assign sel_rw    = sel ? rw1_i : rw0_i;
    assign sel_addr  = sel ? addr1_i : addr0_i;
    assign sel_wdata = sel ? wdata1_i : wdata0_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_gnt   <= 1'b1;
            mem_en_o   <= 1'b0;
            mem_rw_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            mem_en_o <= acc;
            if (acc) begin
                last_gnt   <= sel;
                mem_rw_o   <= sel_rw;
                mem_addr_o <= sel_addr;
                mem_data_o <= sel_wdata;
            end
        end
    end

    // Return pipeline tracks reads until the memory output is valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid  <= 1'b0;
            s1_id     <= 1'b0;
            s2_valid  <= 1'b0;
            s2_id     <= 1'b0;
            rvalid0_o <= 1'b0;
            rvalid1_o <= 1'b0;
            rdata_o   <= '0;
        end else begin
            s1_valid  <= acc & sel_rw;
            s1_id     <= sel;
            s2_valid  <= s1_valid;
            s2_id     <= s1_id;
            rvalid0_o <= s2_valid & ~s2_id;
            rvalid1_o <= s2_valid & s2_id;
            if (s2_valid) begin
                rdata_o <= mem_data_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous memory model.
// Inputs change on the falling edge; outputs are sampled just after it.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, rw0, req1, rw1;
    logic [7:0]   addr0, addr1;
    logic [255:0] wdata0, wdata1;
    logic         gnt0, gnt1, rvalid0, rvalid1;
    logic [255:0] rdata;
    logic         mem_en, mem_rw;
    logic [7:0]   mem_addr;
    logic [255:0] mem_wd;
    logic [255:0] mem_rd;

    logic [255:0] mem [256];
    logic [255:0] mrd;
    logic         mrv;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .rw0_i(rw0), .addr0_i(addr0), .wdata0_i(wdata0),
        .req1_i(req1), .rw1_i(rw1), .addr1_i(addr1), .wdata1_i(wdata1),
        .gnt0_o(gnt0), .gnt1_o(gnt1),
        .rvalid0_o(rvalid0), .rvalid1_o(rvalid1), .rdata_o(rdata),
        .mem_en_o(mem_en), .mem_rw_o(mem_rw),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wd),
        .mem_data_i(mem_rd)
    );

    always @(posedge clk) begin
        mrv <= mem_en & mem_rw;
        if (mem_en) begin
            if (mem_rw) mrd <= mem[mem_addr];
            else mem[mem_addr] <= mem_wd;
        end
    end

    assign mem_rd = mrv ? mrd : {256{1'bx}};

    task automatic idle_inputs();
        req0 = 0; rw0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; rw1 = 0; addr1 = 0; wdata1 = 0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [255:0] d);
        @(negedge clk);
        req0 = 1; rw0 = 0; addr0 = a; wdata0 = d;
        @(negedge clk);
        req0 = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        req0 = 1; req1 = 1;
        #2;
        total++;
        if (gnt0 !== 0 || gnt1 !== 0) begin
            bad++; $display("FAIL reset_gnt got %b%b want 00", gnt0, gnt1);
        end
        @(negedge clk); #1;
        total++;
        if (mem_en !== 0 || mem_rw !== 0 || mem_addr !== 0) begin
            bad++; $display("FAIL reset_mem got en=%b rw=%b a=%h want 0", mem_en, mem_rw, mem_addr);
        end
        total++;
        if (rvalid0 !== 0 || rvalid1 !== 0 || rdata !== 0 || mem_wd !== 0) begin
            bad++; $display("FAIL reset_ret got rv=%b%b rdata=%h", rvalid0, rvalid1, rdata);
        end
        idle_inputs();
        rst = 0;
    endtask

    task automatic test_write_read();
        logic [255:0] pat;
        pat = {32{8'hA5}};
        @(negedge clk);
        req0 = 1; rw0 = 0; addr0 = 8'h05; wdata0 = pat;
        #1;
        total++;
        if (gnt0 !== 1 || gnt1 !== 0) begin
            bad++; $display("FAIL wr_gnt got %b%b want 10", gnt0, gnt1);
        end
        @(negedge clk);
        rw0 = 1;
        #1;
        total++;
        if (mem_en !== 1 || mem_rw !== 0 || mem_addr !== 8'h05 || mem_wd !== pat) begin
            bad++; $display("FAIL wr_issue got en=%b rw=%b a=%h", mem_en, mem_rw, mem_addr);
        end
        total++;
        if (gnt0 !== 1) begin
            bad++; $display("FAIL rd_gnt got %b want 1", gnt0);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            req0 = 0;
            #1;
            if (k == 1) begin
                total++;
                if (mem_en !== 1 || mem_rw !== 1 || mem_addr !== 8'h05) begin
                    bad++; $display("FAIL rd_issue got en=%b rw=%b a=%h", mem_en, mem_rw, mem_addr);
                end
            end
            total++;
            if (rvalid0 !== (k == 3) || rvalid1 !== 0) begin
                bad++; $display("FAIL rd_rvalid k=%0d got %b%b want %b0", k, rvalid0, rvalid1, k == 3);
            end
            if (k == 3) begin
                total++;
                if (rdata !== pat) begin
                    bad++; $display("FAIL rd_data got %h want %h", rdata, pat);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_alternate();
        logic [255:0] d0, d1;
        d0 = 256'd111; d1 = 256'd222;
        preload(8'h20, d0);
        preload(8'h21, d1);
        pulse_reset();
        req0 = 1; rw0 = 1; addr0 = 8'h20;
        req1 = 1; rw1 = 1; addr1 = 8'h21;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++;
            if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin
                bad++; $display("FAIL alt_gnt i=%0d got %b%b", i, gnt0, gnt1);
            end
            if (i >= 3) begin
                total++;
                if (rvalid0 !== ((i - 3) % 2 == 0) || rvalid1 !== ((i - 3) % 2 == 1)) begin
                    bad++; $display("FAIL alt_rv i=%0d got %b%b", i, rvalid0, rvalid1);
                end
                total++;
                if (rdata !== (((i - 3) % 2 == 0) ? d0 : d1)) begin
                    bad++; $display("FAIL alt_data i=%0d got %h", i, rdata);
                end
            end
            @(negedge clk);
        end
        idle_inputs();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_ordering();
        preload(8'h10, 256'h55);
        @(negedge clk);
        req1 = 1; rw1 = 0; addr1 = 8'h10; wdata1 = 256'h1;
        #1;
        total++;
        if (gnt1 !== 1 || gnt0 !== 0) begin
            bad++; $display("FAIL ord_wgnt got %b%b want 01", gnt0, gnt1);
        end
        @(negedge clk);
        req1 = 0;
        req0 = 1; rw0 = 1; addr0 = 8'h10;
        #1;
        total++;
        if (gnt0 !== 1) begin
            bad++; $display("FAIL ord_rgnt got %b want 1", gnt0);
        end
        @(negedge clk);
        req0 = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (rvalid0 !== 1 || rdata !== 256'h1) begin
            bad++; $display("FAIL ord_data got rv=%b d=%h want 1/1", rvalid0, rdata);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            total++;
            if (rdata !== 256'h1 || mem_en !== 0 || rvalid0 !== 0) begin
                bad++; $display("FAIL ord_hold k=%0d got d=%h en=%b rv=%b", k, rdata, mem_en, rvalid0);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 8; a++) preload(a[7:0], 256'(a));
        repeat (3) @(negedge clk);
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                req0 = 1; rw0 = 1; addr0 = c[7:0];
            end else begin
                req0 = 0;
            end
            #1;
            if (c < 8) begin
                total++;
                if (gnt0 !== 1) begin
                    bad++; $display("FAIL b2b_gnt c=%0d got %b want 1", c, gnt0);
                end
            end
            total++;
            if (mem_en !== (c >= 1 && c <= 8)) begin
                bad++; $display("FAIL b2b_en c=%0d got %b", c, mem_en);
            end
            total++;
            if (rvalid0 !== (c >= 3 && c <= 10)) begin
                bad++; $display("FAIL b2b_rv c=%0d got %b", c, rvalid0);
            end
            if (c >= 3 && c <= 10) begin
                total++;
                if (rdata !== 256'(c - 3)) begin
                    bad++; $display("FAIL b2b_data c=%0d got %h want %0d", c, rdata, c - 3);
                end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        preload(8'h30, 256'h77);
        repeat (2) @(negedge clk);
        req0 = 1; rw0 = 1; addr0 = 8'h30;
        @(negedge clk);
        req0 = 1; rw0 = 0; req1 = 1; rw1 = 0;
        rst = 1;
        #1;
        total++;
        if (mem_en !== 0 || rdata !== 0 || gnt0 !== 0 || gnt1 !== 0) begin
            bad++; $display("FAIL rstmid got en=%b d=%h g=%b%b", mem_en, rdata, gnt0, gnt1);
        end
        @(negedge clk);
        rst = 0;
        #1;
        total++;
        if (gnt0 !== 1 || gnt1 !== 0) begin
            bad++; $display("FAIL rstmid_tie got %b%b want 10", gnt0, gnt1);
        end
        @(negedge clk);
        req0 = 0;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rvalid0 !== 0 || rvalid1 !== 0) begin
                bad++; $display("FAIL rstmid_rv k=%0d got %b%b want 00", k, rvalid0, rvalid1);
            end
            @(negedge clk);
            req1 = 0;
            #1;
        end
        idle_inputs();
    endtask

    task automatic test_fairness();
        @(negedge clk);
        req0 = 1; rw0 = 0; addr0 = 8'h40;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (gnt0 !== 1) begin
                bad++; $display("FAIL fair_solo c=%0d got %b want 1", c, gnt0);
            end
            @(negedge clk);
        end
        req1 = 1; rw1 = 0; addr1 = 8'h41;
        #1;
        total++;
        if (gnt1 !== 1 || gnt0 !== 0) begin
            bad++; $display("FAIL fair_join got %b%b want 01", gnt0, gnt1);
        end
        @(negedge clk);
        req1 = 0;
        #1;
        total++;
        if (gnt0 !== 1) begin
            bad++; $display("FAIL fair_back got %b want 1", gnt0);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alternate();
        test_ordering();
        test_back_to_back();
        test_reset_mid();
        test_fairness();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and sequencer for the matrix engine's 256 x 256-bit synchronous single-port scratch memory. It accepts read/write commands from two requesters, for example the host loader and the matrix compute unit, and drives the memory's enable, read/write, address and data pins. It returns read data with a fixed latency and a per-requester valid pulse. It sits directly in front of the memory; no other block drives the memory pins.

## Interface
- DATA_W, 256, memory word width
- ADDR_W, 8, memory address width
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- req0_i / req1_i  input  1  command request, held until granted
- rw0_i / rw1_i  input  1  1 = read, 0 = write
- addr0_i / addr1_i  input  ADDR_W  command address
- wdata0_i / wdata1_i  input  DATA_W  write data, ignored for reads
- gnt0_o / gnt1_o  output  1  combinational grant; command accepted at the edge where reqK_i & gntK_o
- rvalid0_o / rvalid1_o  output  1  one-cycle pulse: rdata_o holds this requester's read result
- rdata_o  output  DATA_W  registered read data, shared by both requesters
- mem_en_o  output  1  memory enable, registered
- mem_rw_o  output  1  memory read/write select, registered
- mem_addr_o  output  ADDR_W  memory address, registered
- mem_data_o  output  DATA_W  memory write data, registered
- mem_data_i  input  DATA_W  memory read data; high-impedance when the memory is not enabled

## Operation
- At most one grant per cycle. gntK_o = reqK_i & (K wins arbitration) & !rst_i.
- Arbitration:
  - Only one requester active: it wins.
  - Both active: the requester not granted most recently (last_gnt register) wins.
  - last_gnt updates only on an accepted command. Reset value is 1, so requester 0 wins the first tie.
- Issue stage, registered:
  - On acceptance, next cycle: mem_en_o=1, mem_rw_o=rwK_i, mem_addr_o=addrK_i, mem_data_o=wdataK_i.
  - With no acceptance, next cycle: mem_en_o=0. The other mem_* outputs hold their last values.
- Return pipeline, 2 stages, each {valid, id}:
  - Stage 1 loads {accepted & read, K} at the accept edge.
  - Stage 2 loads stage 1 at the next edge. While stage 2 is valid, mem_data_i holds the result.
  - At the following edge: rdata_o <= mem_data_i and rvalid{id}_o <= 1. Otherwise rvalid*_o <= 0.
- rdata_o holds its value until the next read return. It is never loaded from mem_data_i when no read is returning, so the memory's Z output never propagates.
- Writes produce no response. Completion is implied at the edge after issue.
- Ordering: commands execute in acceptance order. A read accepted the cycle after a write to the same address returns the new data.
- Reset (async, any time):
  - All registers clear: mem_en_o=0, mem_rw_o=0, mem_addr_o=0, mem_data_o=0, rdata_o=0, rvalid*_o=0, pipeline valids=0, last_gnt=1.
  - gnt*_o=0 while rst_i is high.
  - In-flight commands are dropped, and no rvalid is produced for them after reset releases.

## Timing
- Accept at edge E0 (cycle 0 has req & gnt high).
- Cycle 1: mem pins driven. The memory samples at E1.
- Cycle 2: mem_data_i valid. The arbiter captures at E2.
- Cycle 3: rvalidK_o=1 and rdata_o valid. Read latency is 3 cycles from the accept edge.
- Throughput is one command per cycle, back-to-back, with any mix of reads and writes.
- Requester protocol:
  - After acceptance, the requester may present a new command in the next cycle.
  - An ungranted request must stay stable until it is granted.
- A requester streaming continuously is guaranteed a grant at least every 2nd cycle when the other requester is also streaming.

## Test plan
- Req0 write addr 0x05 = 0xA5..A5 (all bytes), then read 0x05 -> gnt0 same cycle each, mem_en_o high one cycle after each accept, rvalid0_o pulses 3 cycles after the read accept, rdata_o=0xA5..A5, rvalid1_o stays 0.
- Both requesters hold reads continuously from reset -> grants alternate 0,1,0,1. rvalid pulses alternate with the matching rdata_o. First grant goes to req0.
- Req1 writes 0x10 = 0x1 and req0 reads 0x10 on the next cycle -> read returns 0x1 (ordering). rdata_o then holds 0x1 through 5 idle cycles with mem_en_o=0.
- 8 back-to-back reads by req0, addrs 0..7, preloaded with value = addr -> mem_en_o high 8 consecutive cycles, 8 consecutive rvalid0_o pulses, rdata_o = 0..7.
- Reset asserted 1 cycle after a read accept (mid-pipeline) -> all outputs 0 immediately. After release, no rvalid pulse. The first tie grant goes to req0.
- Req0 held, req1 absent -> req0 granted every cycle. Req1 asserts mid-stream -> granted within 2 cycles.
